multicycle_control: RTL

//  Main control FSM for the multicycle MIPS-subset datapath; sequences PC, IR, memory, regfile and ALU.

---
 rtl/multicycle_control_pkg.sv | 73 +++++++
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-subset control FSM.
// Holds the state encoding, supported opcodes, ALU operation codes, mux
// select encodings, the packed control-strobe bundle and the decode helper
// that maps an opcode to the state following S_DECODE.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  // State entered from S_DECODE for a given opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEMADDR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = S_ADDIEX;
      default:      nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Sequences PC, IR, unified memory, register file and ALU for R-type, LW,
// SW, BEQ, J and ADDI. Memory accesses stall on mem_ready. Unsupported
// opcodes park the FSM in S_ILLEGAL with a sticky error until reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; forces all strobes low
//   opcode         IR[31:26], sampled only in S_DECODE
//   mem_ready      memory completes current read/write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load when ALU zero (BEQ)
//   pc_source      00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d         memory address: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       latch memory data into IR
//   mem_to_reg     regfile write data: 0 ALUOut, 1 MDR
//   reg_dst        regfile write address: 0 rt, 1 rd
//   reg_write      regfile write enable
//   alu_src_a      0 PC, 1 register A
//   alu_src_b      00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op         00 add, 01 sub, 10 funct-decoded
//   error          sticky illegal-opcode flag
//   retired        instructions completed since reset (wraps)
//   state          current state, debug only
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               error,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           decoded;
  logic [5:0]       op_q;
  logic             error_q;
  logic [CNT_W-1:0] retired_q;
  ctl_t             ctl;

  assign decoded = decode_next(opcode);

  // op_q keeps the opcode past S_DECODE so S_MEMADDR can tell LW from SW
  // after the IR bus has moved on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          op_q    <= opcode;
          state_q <= decoded;
          if (decoded == S_ILLEGAL) error_q <= 1'b1;
        end
        S_MEMADDR: begin
          state_q <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          if (mem_ready) state_q <= S_MEMWB;
        end
        S_MEMWR: begin
          if (mem_ready) begin
            state_q   <= S_FETCH;
            retired_q <= retired_q + CNT_ONE;
          end
        end
        S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + CNT_ONE;
        end
        S_EXEC:    state_q <= S_RTYPEWB;
        S_ADDIEX:  state_q <= S_ADDIWB;
        S_ILLEGAL: state_q <= S_ILLEGAL;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode; mem_ready only qualifies the IR/PC update at fetch so the
  // instruction is captured in the same cycle the memory delivers it.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
        ctl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
      end
      default: ctl = '0;
    endcase
    // Reset abandons any transaction in flight: no strobe may reach the
    // datapath while rst is high, whatever state the flops still hold.
    if (rst) ctl = '0;
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;

  assign error   = error_q;
  assign retired = retired_q;
  assign state   = STATE_W'(state_q);

endmodule
